// File: rtl/seg7_pkg.sv
// Shared seven-segment pattern constants (active-low, a..g from MSB to LSB)
// and a helper that turns a decimal integer parameter into a BCD vector.
package seg7_pkg;

    localparam int MAX_DIGITS = 6;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001101;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Widest possible result; callers keep the low 4*DIGITS bits.
    function automatic logic [4*MAX_DIGITS-1:0] dec_to_bcd(input int unsigned value);
        logic [4*MAX_DIGITS-1:0] bcd;
        int unsigned             rest;
        bcd  = '0;
        rest = value;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            bcd[4*k +: 4] = 4'(rest % 10);
            rest          = rest / 10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/bcd_counter_hex_if.sv
// Control and display bundle of the BCD counter: the master drives the
// count controls, the slave (counter) drives the count, flags and HEX pins.
interface bcd_counter_hex_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  at_max;
    logic                  at_min;
    logic                  tc;
    logic                  load_err;
    logic [0:7*DIGITS-1]   HEX;

    modport master (
        output en, up, load, load_val,
        input  count, at_max, at_min, tc, load_err, HEX
    );

    modport slave (
        input  en, up, load, load_val,
        output count, at_max, at_min, tc, load_err, HEX
    );

endinterface

// File: rtl/seg7_decode.sv
// One BCD nibble to active-low seven-segment pattern; non-decimal codes and
// blanked digits show all segments off.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_counter_hex.sv
// Multi-digit BCD up/down counter with bounds, wrap/saturate, parallel load
// and registered seven-segment outputs decoded from the next count value.
module bcd_counter_hex
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int MIN       = 0,
    parameter int MAX       = 99,
    parameter int RESET_VAL = 0,
    parameter int WRAP      = 0,
    parameter int BLANK_LZ  = 0
) (
    input logic              clock,
    input logic              reset,
    bcd_counter_hex_if.slave bus
);

    localparam int W = 4 * DIGITS;
    localparam int H = 7 * DIGITS;

    localparam logic [4*MAX_DIGITS-1:0] MIN_FULL = dec_to_bcd(MIN);
    localparam logic [4*MAX_DIGITS-1:0] MAX_FULL = dec_to_bcd(MAX);
    localparam logic [4*MAX_DIGITS-1:0] RST_FULL = dec_to_bcd(RESET_VAL);
    localparam logic [W-1:0]            MIN_BCD  = MIN_FULL[W-1:0];
    localparam logic [W-1:0]            MAX_BCD  = MAX_FULL[W-1:0];
    localparam logic [W-1:0]            RST_BCD  = RST_FULL[W-1:0];

    logic [W-1:0]      count_q, count_d;
    logic [W-1:0]      next_val;
    logic [W-1:0]      inc_val, dec_val;
    logic              at_max_q, at_min_q;
    logic              tc_q, tc_d;
    logic              load_err_q, load_err_d;
    logic [0:H-1]      hex_q, hex_d;
    logic [DIGITS-1:0] carry, borrow;
    logic [DIGITS-1:0] blank_v;
    logic              load_bad;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    // Ripple decimal carry/borrow; each digit also drives its own decoder.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] d;
        assign d = count_q[4*k +: 4];

        assign inc_val[4*k +: 4] = !carry[k]     ? d :
                                   (d == 4'd9)   ? 4'd0 : d + 4'd1;
        assign dec_val[4*k +: 4] = !borrow[k]    ? d :
                                   (d == 4'd0)   ? 4'd9 : d - 4'd1;

        if (k + 1 < DIGITS) begin : g_chain
            assign carry[k+1]  = carry[k]  & (d == 4'd9);
            assign borrow[k+1] = borrow[k] & (d == 4'd0);
        end

        seg7_decode u_dec (
            .bcd_i   (next_val[4*k +: 4]),
            .blank_i (blank_v[k]),
            .seg_o   (hex_d[7*k +: 7])
        );
    end

    always_comb begin
        load_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bus.load_val[4*k +: 4] > 4'd9) load_bad = 1'b1;
        end
    end

    // Valid BCD orders the same as plain binary, so bounds compare directly.
    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (load_bad)                  load_err_d = 1'b1;
            else if (bus.load_val < MIN_BCD) count_d  = MIN_BCD;
            else if (bus.load_val > MAX_BCD) count_d  = MAX_BCD;
            else                             count_d  = bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (count_q < MAX_BCD) begin
                    count_d = inc_val;
                end else if (WRAP != 0) begin
                    count_d = MIN_BCD;
                    tc_d    = 1'b1;
                end
            end else begin
                if (count_q > MIN_BCD) begin
                    count_d = dec_val;
                end else if (WRAP != 0) begin
                    count_d = MAX_BCD;
                    tc_d    = 1'b1;
                end
            end
        end
    end

    // The decoders look at the value the count register is about to take.
    assign next_val = reset ? RST_BCD : count_d;

    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank_v    = '0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            upper_zero = upper_zero & (next_val[4*k +: 4] == 4'd0);
            blank_v[k] = (BLANK_LZ != 0) & upper_zero;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= RST_BCD;
            at_max_q   <= (RST_BCD == MAX_BCD);
            at_min_q   <= (RST_BCD == MIN_BCD);
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            at_max_q   <= (count_d == MAX_BCD);
            at_min_q   <= (count_d == MIN_BCD);
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
        hex_q <= hex_d;
    end

    assign bus.count    = count_q;
    assign bus.at_max   = at_max_q;
    assign bus.at_min   = at_min_q;
    assign bus.tc       = tc_q;
    assign bus.load_err = load_err_q;
    assign bus.HEX      = hex_q;

endmodule

// File: tb/tb_bcd_counter_hex.sv
// Bench for bcd_counter_hex: four parameter sets run side by side and are
// checked every cycle against an integer-valued model, plus directed pins.
module tb_bcd_counter_hex;

    localparam int NI = 4;

    // Instance configurations: digits, min, max, reset value, wrap, blank.
    localparam int A_DG = 2, A_MN = 1,  A_MX = 10,  A_RV = 1,  A_WR = 0, A_BZ = 0;
    localparam int B_DG = 3, B_MN = 0,  B_MX = 999, B_RV = 0,  B_WR = 1, B_BZ = 1;
    localparam int C_DG = 3, C_MN = 20, C_MX = 199, C_RV = 50, C_WR = 1, C_BZ = 0;
    localparam int D_DG = 1, D_MN = 5,  D_MX = 5,   D_RV = 5,  D_WR = 1, D_BZ = 0;

    int dg  [NI] = '{A_DG, B_DG, C_DG, D_DG};
    int mn  [NI] = '{A_MN, B_MN, C_MN, D_MN};
    int mx  [NI] = '{A_MX, B_MX, C_MX, D_MX};
    int rv  [NI] = '{A_RV, B_RV, C_RV, D_RV};
    int wr  [NI] = '{A_WR, B_WR, C_WR, D_WR};
    int blz [NI] = '{A_BZ, B_BZ, C_BZ, D_BZ};

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                                 7'b0000000, 7'b0000100};

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- stimulus state ----------------
    logic        en_v   [NI];
    logic        up_v   [NI];
    logic        load_v [NI];
    logic [23:0] lval_v [NI];

    bcd_counter_hex_if #(.DIGITS(A_DG)) if_a ();
    bcd_counter_hex_if #(.DIGITS(B_DG)) if_b ();
    bcd_counter_hex_if #(.DIGITS(C_DG)) if_c ();
    bcd_counter_hex_if #(.DIGITS(D_DG)) if_d ();

    assign if_a.en = en_v[0]; assign if_a.up = up_v[0]; assign if_a.load = load_v[0];
    assign if_b.en = en_v[1]; assign if_b.up = up_v[1]; assign if_b.load = load_v[1];
    assign if_c.en = en_v[2]; assign if_c.up = up_v[2]; assign if_c.load = load_v[2];
    assign if_d.en = en_v[3]; assign if_d.up = up_v[3]; assign if_d.load = load_v[3];
    assign if_a.load_val = lval_v[0][7:0];
    assign if_b.load_val = lval_v[1][11:0];
    assign if_c.load_val = lval_v[2][11:0];
    assign if_d.load_val = lval_v[3][3:0];

    bcd_counter_hex #(.DIGITS(A_DG), .MIN(A_MN), .MAX(A_MX), .RESET_VAL(A_RV),
                      .WRAP(A_WR), .BLANK_LZ(A_BZ))
        u_a (.clock(clock), .reset(reset), .bus(if_a));
    bcd_counter_hex #(.DIGITS(B_DG), .MIN(B_MN), .MAX(B_MX), .RESET_VAL(B_RV),
                      .WRAP(B_WR), .BLANK_LZ(B_BZ))
        u_b (.clock(clock), .reset(reset), .bus(if_b));
    bcd_counter_hex #(.DIGITS(C_DG), .MIN(C_MN), .MAX(C_MX), .RESET_VAL(C_RV),
                      .WRAP(C_WR), .BLANK_LZ(C_BZ))
        u_c (.clock(clock), .reset(reset), .bus(if_c));
    bcd_counter_hex #(.DIGITS(D_DG), .MIN(D_MN), .MAX(D_MX), .RESET_VAL(D_RV),
                      .WRAP(D_WR), .BLANK_LZ(D_BZ))
        u_d (.clock(clock), .reset(reset), .bus(if_d));

    // Observed outputs, left-justified to a common layout:
    // {count padded to 24, HEX padded with ones to 42, at_max, at_min, tc, load_err}
    logic [69:0] act_w [NI];
    assign act_w[0] = {16'h0, if_a.count, if_a.HEX, {28{1'b1}},
                       if_a.at_max, if_a.at_min, if_a.tc, if_a.load_err};
    assign act_w[1] = {12'h0, if_b.count, if_b.HEX, {21{1'b1}},
                       if_b.at_max, if_b.at_min, if_b.tc, if_b.load_err};
    assign act_w[2] = {12'h0, if_c.count, if_c.HEX, {21{1'b1}},
                       if_c.at_max, if_c.at_min, if_c.tc, if_c.load_err};
    assign act_w[3] = {20'h0, if_d.count, if_d.HEX, {35{1'b1}},
                       if_d.at_max, if_d.at_min, if_d.tc, if_d.load_err};

    // ---------------- model ----------------
    int          cnt_m [NI];
    bit          tc_m  [NI];
    bit          le_m  [NI];
    logic [69:0] exp_q [$];
    int          n_vec   = 0;
    int          n_err   = 0;
    int          cyc     = 0;
    bit          started = 0;

    function automatic logic [23:0] to_bcd(input int value);
        logic [23:0] r;
        int          v;
        r = '0;
        v = value;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_step(input int i);
        int v;
        bit bad;
        tc_m[i] = 0;
        le_m[i] = 0;
        if (reset) begin
            cnt_m[i] = rv[i];
        end else if (load_v[i]) begin
            bad = 0;
            v   = 0;
            for (int k = dg[i] - 1; k >= 0; k--) begin
                int n;
                n = int'(lval_v[i][4*k +: 4]);
                if (n > 9) bad = 1;
                v = v * 10 + n;
            end
            if (bad) le_m[i] = 1;
            else     cnt_m[i] = (v < mn[i]) ? mn[i] : (v > mx[i]) ? mx[i] : v;
        end else if (en_v[i]) begin
            if (up_v[i]) begin
                if (cnt_m[i] < mx[i]) cnt_m[i] = cnt_m[i] + 1;
                else if (wr[i] != 0) begin cnt_m[i] = mn[i]; tc_m[i] = 1; end
            end else begin
                if (cnt_m[i] > mn[i]) cnt_m[i] = cnt_m[i] - 1;
                else if (wr[i] != 0) begin cnt_m[i] = mx[i]; tc_m[i] = 1; end
            end
        end
    endtask

    function automatic logic [69:0] exp_vec(input int i);
        logic [0:41] h;
        int          p;
        int          d;
        h = '1;
        p = 1;
        for (int k = 0; k < dg[i]; k++) begin
            d = (cnt_m[i] / p) % 10;
            if (blz[i] != 0 && k > 0 && cnt_m[i] < p) h[7*k +: 7] = 7'h7f;
            else                                      h[7*k +: 7] = seg_tab[d];
            p = p * 10;
        end
        return {to_bcd(cnt_m[i]), h, cnt_m[i] == mx[i], cnt_m[i] == mn[i], tc_m[i], le_m[i]};
    endfunction

    // ---------------- scoreboard: every cycle, every instance ----------------
    always @(posedge clock) begin : cmp
        logic [69:0] e;
        if (reset) started = 1;
        if (started) begin
            for (int i = 0; i < NI; i++) begin
                model_step(i);
                exp_q.push_back(exp_vec(i));
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                e = exp_q.pop_front();
                n_vec++;
                if (act_w[i] !== e) begin
                    n_err++;
                    $display("FAIL inst%0d cycle %0d: dut=%h model=%h", i, cyc, act_w[i], e);
                end
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            en_v[i]   = 1'b0;
            up_v[i]   = 1'b0;
            load_v[i] = 1'b0;
            lval_v[i] = '0;
        end
    endtask

    task automatic load_one(input int i, input logic [23:0] v);
        load_v[i] = 1'b1;
        lval_v[i] = v;
        tick();
        load_v[i] = 1'b0;
    endtask

    task automatic rand_inputs();
        reset = ($urandom_range(0, 199) == 0);
        for (int i = 0; i < NI; i++) begin
            en_v[i]   = ($urandom_range(0, 3) != 0);
            up_v[i]   = ($urandom_range(0, 1) != 0);
            load_v[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) lval_v[i] = 24'($urandom);
            else lval_v[i] = to_bcd(int'($urandom_range(0, 10 ** dg[i] - 1)));
        end
    endtask

    // ---------------- directed then random sequence ----------------
    initial begin
        idle_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        check("rst_a_count", if_a.count, 8'h01);
        check("rst_a_at_min", if_a.at_min, 1'b1);
        check("rst_a_hex", if_a.HEX, {7'b1001111, 7'b0000001});
        check("rst_c_count", if_c.count, 12'h050);
        check("rst_model_a", cnt_m[0], 1);

        // Saturating count up on A
        en_v[0] = 1'b1;
        up_v[0] = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            tick();
            check("sat_tc", if_a.tc, 1'b0);
            if (s == 1) check("sat_first", if_a.count, 8'h02);
        end
        check("sat_count", if_a.count, 8'h10);
        check("sat_at_max", if_a.at_max, 1'b1);
        check("sat_hex", if_a.HEX, {7'b0000001, 7'b1001111});
        en_v[0] = 1'b0;

        // Wrap down on B from 000
        en_v[1] = 1'b1;
        up_v[1] = 1'b0;
        tick();
        check("wrap_count", if_b.count, 12'h999);
        check("wrap_tc", if_b.tc, 1'b1);
        check("wrap_model", cnt_m[1], 999);
        tick();
        check("wrap_next", if_b.count, 12'h998);
        check("wrap_tc_off", if_b.tc, 1'b0);
        en_v[1] = 1'b0;

        // Loads on C: clamp, reject, then reset beats load and en
        load_one(2, 24'h250);
        check("load_clamp", if_c.count, 12'h199);
        check("load_clamp_max", if_c.at_max, 1'b1);
        load_one(2, 24'h1A3);
        check("load_bad_hold", if_c.count, 12'h199);
        check("load_err_pulse", if_c.load_err, 1'b1);
        tick();
        check("load_err_off", if_c.load_err, 1'b0);
        load_v[2] = 1'b1;
        lval_v[2] = 24'h030;
        en_v[2]   = 1'b1;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        idle_all();
        check("rst_prio", if_c.count, 12'h050);
        check("rst_prio_model", cnt_m[2], 50);

        // Leading-zero blanking on B
        load_one(1, 24'h007);
        check("blank_007", if_b.HEX, {7'b0001101, 14'h3fff});
        load_one(1, 24'h000);
        check("blank_000", if_b.HEX, {7'b0000001, 14'h3fff});

        // Carry and borrow across digits on B
        load_one(1, 24'h099);
        en_v[1] = 1'b1;
        up_v[1] = 1'b1;
        tick();
        check("carry", if_b.count, 12'h100);
        check("carry_hex", if_b.HEX, {7'b0000001, 7'b0000001, 7'b1001111});
        up_v[1] = 1'b0;
        tick();
        check("borrow", if_b.count, 12'h099);
        check("borrow_hex", if_b.HEX, {7'b0000100, 7'b0000100, 7'h7f});
        en_v[1] = 1'b0;

        // MIN == MAX with wrap: constant count, tc on every enabled cycle
        en_v[3] = 1'b1;
        up_v[3] = 1'b1;
        tick();
        check("const_tc_up", if_d.tc, 1'b1);
        check("const_count", if_d.count, 4'h5);
        up_v[3] = 1'b0;
        tick();
        check("const_tc_dn", if_d.tc, 1'b1);
        check("const_count2", if_d.count, 4'h5);
        idle_all();
        tick();

        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            tick();
        end
        reset = 1'b0;
        idle_all();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_counter_hex.md
# bcd_counter_hex

Parametrised multi-digit BCD up/down counter with direct seven-segment drive, used wherever a lab design needs a stepped or bounded count shown on HEX displays. It generalises the single-digit step counter to DIGITS decimal digits with programmable bounds, count direction, wrap or saturate mode, parallel load and optional leading-zero blanking. The count and all segment outputs are registered. It sits between the board clock/key inputs and the HEX pins.

## Interface

**Parameters**

- `DIGITS`, default 2: number of BCD digits, valid range 1–6.
- `MIN`, default 0: lower bound, as a decimal integer.
- `MAX`, default 99: upper bound, as a decimal integer. Requires MIN ≤ MAX ≤ 10^DIGITS−1.
- `RESET_VAL`, default 0: count value after reset, as a decimal integer. Requires MIN ≤ RESET_VAL ≤ MAX.
- `WRAP`, default 0: 0 = saturate at the bounds; 1 = wrap MAX↔MIN.
- `BLANK_LZ`, default 0: 1 = blank leading-zero digits. Digit 0 is never blanked.

**Ports**

- `clock`, input, 1: sole clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `en`, input, 1: count enable, one step per cycle while high.
- `up`, input, 1: direction, 1 = increment, 0 = decrement.
- `load`, input, 1: parallel load strobe.
- `load_val`, input, 4*DIGITS: BCD value to load. Nibble k is digit k; digit 0 is least significant.
- `count`, output, 4*DIGITS: current count in BCD.
- `at_max`, output, 1: high while count == MAX.
- `at_min`, output, 1: high while count == MIN.
- `tc`, output, 1: one-cycle pulse on the edge where a wrap occurs.
- `load_err`, output, 1: one-cycle pulse when a load is rejected.
- `HEX`, output, 7*DIGITS, declared [0:7*DIGITS-1]: active-low segments. Digit k occupies HEX[7k : 7k+6] in a, b, c, d, e, f, g order.

## Operation

- Priority on each edge, highest first: reset, then load, then en, then hold.
- Reset:
  - count = RESET_VAL.
  - at_max and at_min are set per that value.
  - tc = 0 and load_err = 0.
  - HEX = decode(RESET_VAL).
  - Reset asserted mid-count overrides load and en on the same edge.
- Load:
  - If any nibble of load_val is > 9, the load is rejected: count holds and load_err pulses.
  - Otherwise a valid BCD value is clamped into [MIN, MAX] and loaded. An out-of-range value is not an error.
- en with up = 1:
  - count < MAX: count + 1, with per-digit decimal carry (09 → 10, 99 → 100).
  - count == MAX and WRAP = 0: hold.
  - count == MAX and WRAP = 1: count = MIN and tc pulses.
- en with up = 0:
  - count > MIN: count − 1, with per-digit borrow (10 → 09).
  - count == MIN: hold when WRAP = 0; count = MAX and tc pulses when WRAP = 1.
- MIN == MAX: the count is constant. en never changes it, and with WRAP = 1 tc pulses on every enabled cycle.
- Decode, per nibble:
  - 0 → 0000001, 1 → 1001111, 2 → 0010010, 3 → 0000110, 4 → 1001100
  - 5 → 0100100, 6 → 0100000, 7 → 0001101, 8 → 0000000, 9 → 0000100
  - any other value, or a blanked digit → 1111111.
- Blanking: with BLANK_LZ = 1, digit k (k > 0) is blanked when it and every higher digit are 0.

## Timing

- Single clock domain. No combinational path from any input to any output.
- count, at_max, at_min, tc, load_err and HEX all update on the same rising edge.
- HEX is decoded from the next count value and registered, so it never lags count.
- Latency is one cycle from a sampled input to the updated outputs.
- tc and load_err are exactly one cycle wide and are never high simultaneously.
- en held high gives one step per cycle. There is no edge detection, so key debouncing and strobing are external.

## Structure

- Shared package `seg7_pkg`:
  - segment pattern constants SEG_0 … SEG_9 and SEG_BLANK.
  - a function converting a decimal integer parameter to its BCD vector, used for MIN, MAX and RESET_VAL.
- Sub-module `seg7_decode`: combinational 4-bit-to-7-segment decoder with a `blank` input. It is instantiated DIGITS times in a generate loop.
- Counter core: one generate loop of per-digit carry/borrow logic, plus bound compare and clamp in the top module.

## Test plan

- **Reset.** DIGITS=2, MIN=1, MAX=10, RESET_VAL=1, WRAP=0, BLANK_LZ=0. Assert reset for 1 cycle → count=0x01, at_min=1, HEX[0:6]=1001111, HEX[7:13]=0000001.
- **Saturate up.** Same configuration. en=1, up=1 for 12 cycles → count steps 0x02 … 0x10 and then holds at 0x10. at_max=1, tc never asserts, HEX[0:6]=0000001, HEX[7:13]=1001111.
- **Wrap down.** DIGITS=3, MIN=0, MAX=999, WRAP=1. From count=0x000, one enabled cycle with up=0 → count=0x999 and tc=1 for exactly 1 cycle. The next cycle gives 0x998 with tc=0.
- **Load handling.** Load 0x250 with MAX=199 → count=0x199. Load 0x1A3 → count holds and load_err pulses for 1 cycle. Load, en and reset together → count = RESET_VAL.
- **Blanking.** BLANK_LZ=1, DIGITS=3, count=0x007 → HEX[14:20]=1111111, HEX[7:13]=1111111, HEX[0:6]=0001101. Count=0x000 → only digit 0 is shown, as 0000001.
- **Carry/borrow.** Count 0x099 with up=1 → 0x100. Count 0x100 with up=0 → 0x099. Reset asserted mid-run returns to RESET_VAL on the next edge.
